// File: rtl/mbc_multicart_if.sv
// Cartridge bus between the CPU side and the multicart mapper:
// CPU address/data/strobe in one direction, mapped ROM/RAM addresses back.
interface mbc_multicart_if #(
   parameter int ROM_AW = 23,
   parameter int RAM_AW = 17
);
   logic [14:0]       cart_addr;
   logic              cart_a15;
   logic              cart_wr;
   logic [7:0]        cart_di;
   logic [ROM_AW-1:0] mbc_addr;
   logic [RAM_AW-1:0] cram_addr;
   logic              ram_enabled;

   modport master (
      output cart_addr, cart_a15, cart_wr, cart_di,
      input  mbc_addr, cram_addr, ram_enabled
   );

   modport slave (
      input  cart_addr, cart_a15, cart_wr, cart_di,
      output mbc_addr, cram_addr, ram_enabled
   );
endinterface

// File: rtl/mbc_multicart.sv
// Multicart mapper: a menu picks one of GAMES slots, then locks into an
// MBC1/MBC5-style banker confined to that slot's ROM/RAM window.
module mbc_multicart #(
   parameter int  GAMES  = 8,
   parameter int  ROM_AW = 23,
   parameter int  RAM_AW = 17,
   localparam int IDX_W  = $clog2(GAMES)
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             enable,
   input  logic             ce_cpu,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [27:0]      cfg_data,
   mbc_multicart_if.slave   bus,
   input  logic             savestate_load,
   input  logic [63:0]      savestate_data2,
   output logic [63:0]      savestate_back2,
   output logic             locked,
   output logic [IDX_W-1:0] cur_game
);
   localparam int SLOTS = 1 << IDX_W;

   localparam logic [0:0] MENU   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [26:0]      cfg_tab [SLOTS];
   // Valid bits power up cleared; they are never touched by reset.
   logic [SLOTS-1:0] cfg_valid = '0;

   logic [0:0]       state;
   logic [IDX_W-1:0] sel;
   logic [8:0]       rom_bank;
   logic [3:0]       ram_bank;
   logic             ram_en;

   logic             is_locked;
   logic [IDX_W-1:0] eidx;
   logic [26:0]      e;
   logic [8:0]       e_rom_base;
   logic [8:0]       e_rom_mask;
   logic [3:0]       e_ram_base;
   logic [3:0]       e_ram_mask;
   logic             mbc5;
   logic             cart_we;
   logic [7:0]       di;
   logic [8:0]       rom_unit;
   logic [3:0]       ram_unit;
   logic [22:0]      rom_full;
   logic [16:0]      ram_full;
   logic [4:0]       mbc1_lo;
   logic             unused_ss;

   assign is_locked = (state == LOCKED);
   assign eidx      = is_locked ? sel : '0;
   assign e         = cfg_tab[eidx];
   assign e_rom_base = e[8:0];
   assign e_rom_mask = e[17:9];
   assign e_ram_base = e[21:18];
   assign e_ram_mask = e[25:22];
   // The menu program always talks to MBC5 decode rules.
   assign mbc5      = is_locked ? e[26] : 1'b1;

   assign di      = bus.cart_di;
   assign cart_we = bus.cart_wr & ce_cpu & ~bus.cart_a15 & enable;
   assign mbc1_lo = (di[4:0] == 5'd0) ? 5'd1 : di[4:0];

   always_ff @(posedge clk_sys) begin
      if (cfg_we) begin
         cfg_tab[cfg_idx]   <= cfg_data[26:0];
         cfg_valid[cfg_idx] <= cfg_data[27];
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state    <= MENU;
         sel      <= '0;
         rom_bank <= 9'd1;
         ram_bank <= 4'd0;
         ram_en   <= 1'b0;
      end else if (savestate_load) begin
         state    <= savestate_data2[0] ? LOCKED : MENU;
         sel      <= savestate_data2[IDX_W:1];
         rom_bank <= savestate_data2[17:9];
         ram_bank <= savestate_data2[21:18];
         ram_en   <= savestate_data2[22];
      end else if (cart_we) begin
         unique case (bus.cart_addr[14:12])
            3'd0, 3'd1: ram_en <= (di[3:0] == 4'hA);
            3'd2: begin
               if (mbc5) rom_bank[7:0] <= di;
               else      rom_bank      <= {4'b0, mbc1_lo};
            end
            3'd3: begin
               if (mbc5) rom_bank[8] <= di[0];
            end
            3'd4, 3'd5: begin
               ram_bank <= mbc5 ? di[3:0] : {2'b0, di[1:0]};
            end
            3'd6: begin
               if (!is_locked) sel <= di[IDX_W-1:0];
            end
            3'd7: begin
               if (!is_locked && di == 8'hA5 && cfg_valid[sel]) begin
                  state    <= LOCKED;
                  rom_bank <= 9'd1;
                  ram_bank <= 4'd0;
                  ram_en   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign rom_unit = bus.cart_addr[14]
                   ? e_rom_base + (rom_bank & e_rom_mask)
                   : e_rom_base;
   assign ram_unit = e_ram_base + (ram_bank & e_ram_mask);
   assign rom_full = {rom_unit, bus.cart_addr[13:0]};
   assign ram_full = {ram_unit, bus.cart_addr[12:0]};

   assign bus.mbc_addr    = enable ? ROM_AW'(rom_full) : '0;
   assign bus.cram_addr   = enable ? RAM_AW'(ram_full) : '0;
   assign bus.ram_enabled = ram_en & enable;

   assign locked   = is_locked;
   assign cur_game = sel;

   assign savestate_back2 = {41'b0, ram_en, ram_bank, rom_bank,
                             8'(sel), is_locked};

   assign unused_ss = ^savestate_data2;
endmodule
